uart_rx_fifo_path: RTL

//  Parametrised next-generation UART receive path.
//  - Deserialises frames from the Rx line; the receiver generates its own bit timing.
//  - Frame: start bit, WIDTH_SIZE data bits, optional parity bit, STOP_BITS stop bits.
//  - Each word is tagged with parity and framing error flags, then buffered in a DEPTH-entry FIFO.
//  - The FIFO drains over a valid/ready handshake.
//  - Sits between the pad-side Rx line (driven by Tx_path) and the host consumer.

---
 rtl/uart_rx_fifo_path.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_path.sv
// UART receive path: 2-flop Rx synchroniser, frame deserialiser with
// majority-vote sampling, parity/stop checking, and a first-word-fall-through
// FIFO drained over a valid/ready handshake.
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on the synchronised line
// START  | qualifying the start bit; a high majority aborts as a false start
// DATA   | shifting in WIDTH_SIZE data bits, LSB first
// PARITY | sampling the parity bit (only when PF was latched)
// STOP   | sampling STOP_BITS stop bits; the last sample pushes the word
module uart_rx_fifo_path #(
  parameter int WIDTH_SIZE   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Rx,
  input  logic                         PF,
  input  logic                         clr_overrun,
  input  logic                         ready,
  output logic                         valid,
  output logic [WIDTH_SIZE-1:0]        data,
  output logic                         err,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH_SIZE > 1) ? $clog2(WIDTH_SIZE) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH_SIZE + 2;

  localparam logic [TW-1:0] T_M_LO  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_M     = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_M_HI  = TW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [TW-1:0] T_END   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(WIDTH_SIZE - 1);
  localparam logic          S_LAST  = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD = 1'(PARITY_ODD);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state_q, state_d;

  logic                  rx_s1, rxs, rxs_d, armed;
  logic [1:0]            flush;
  logic [TW-1:0]         tick_q;
  logic [BW-1:0]         bit_q;
  logic                  stop_q;
  logic [WIDTH_SIZE-1:0] shreg_q;
  logic [WIDTH_SIZE:0]   sh_next;
  logic                  s0, s1, maj;
  logic                  err_q, ferr_q, pf_q;
  logic                  start_edge, push, stop_bad;
  logic [EW-1:0]         push_word;

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         last_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  do_pop, do_push;

  // Synchroniser plus arming. flush marks when rxs reflects the real line
  // rather than its reset value, so a line held low through reset never arms.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_s1 <= Rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      flush <= {flush[0], 1'b1};
      if (flush[1] && rxs) armed <= 1'b1;
    end
  end

  assign start_edge = armed && rxs_d && !rxs;
  assign maj        = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign sh_next    = {maj, shreg_q};
  assign stop_bad   = ferr_q | ~maj;
  assign push_word  = {stop_bad, err_q, shreg_q};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and push strobe
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START: begin
        if (tick_q == T_M_HI && maj) state_d = IDLE;
        else if (tick_q == T_END)    state_d = DATA;
      end
      DATA:   if (tick_q == T_END && bit_q == B_LAST) state_d = pf_q ? PARITY : STOP;
      PARITY: if (tick_q == T_END) state_d = STOP;
      STOP: begin
        if (tick_q == T_M_HI && stop_q == S_LAST) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, sampling and frame assembly
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
      pf_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      tick_q <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
      ferr_q <= 1'b0;
      if (start_edge) begin
        pf_q  <= PF;
        err_q <= 1'b0;
      end
    end else begin
      tick_q <= (tick_q == T_END) ? '0 : tick_q + 1'b1;
      if (tick_q == T_M_LO) s0 <= rxs;
      if (tick_q == T_M)    s1 <= rxs;
      if (tick_q == T_M_HI) begin
        if (state_q == DATA)   shreg_q <= sh_next[WIDTH_SIZE:1];
        if (state_q == PARITY) err_q   <= ((^shreg_q) ^ maj) != PAR_ODD;
        if (state_q == STOP && !maj) ferr_q <= 1'b1;
      end
      if (tick_q == T_END) begin
        if (state_q == DATA) bit_q  <= bit_q + 1'b1;
        if (state_q == STOP) stop_q <= stop_q + 1'b1;
      end
    end
  end

  assign do_pop  = valid && ready;
  assign do_push = push && (cnt_q != C_FULL || do_pop);

  // FIFO storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_q] <= push_word;
  end

  // FIFO pointers, occupancy, last-popped word and sticky overrun
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem[rd_q];
      end
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (push && !do_push)  overrun <= 1'b1;
      else if (clr_overrun)  overrun <= 1'b0;
    end
  end

  assign valid = (cnt_q != '0);
  assign count = cnt_q;
  assign {frame_err, err, data} = valid ? mem[rd_q] : last_q;

endmodule
